// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the auto-scaled low-frequency counter.
package freq_counter_pkg;

  localparam int unsigned DEFAULT_COUNT_W = 32;
  localparam int unsigned CLK_FREQ_HZ     = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_COUNT,
    ST_DONE
  } period_state_t;

endpackage

// File: rtl/period_counter_if.sv
// Request/result bundle between the period counter and its controller.
interface period_counter_if
  import freq_counter_pkg::*;
#(
  parameter int unsigned COUNT_W = DEFAULT_COUNT_W
);

  logic               start_i;
  logic               signal_i;
  logic               ready_o;
  logic               done_o;
  logic               timeout_o;
  logic [COUNT_W-1:0] period_o;

  modport master (
    output start_i,
    output signal_i,
    input  ready_o,
    input  done_o,
    input  timeout_o,
    input  period_o
  );

  modport slave (
    input  start_i,
    input  signal_i,
    output ready_o,
    output done_o,
    output timeout_o,
    output period_o
  );

endinterface

// File: rtl/period_counter_edge_detector.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module edge_detector (
  input  logic clk_i,
  input  logic reset_i,
  input  logic signal_i,
  output logic edge_tick_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_tick;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= signal_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_sync2 & ~r_prev;
    end
  end

  assign edge_tick_o = r_tick;

endmodule

// File: rtl/period_counter.sv
// Measures the rising-edge-to-rising-edge period of signal_i in clk_i cycles.
module period_counter
  import freq_counter_pkg::*;
#(
  parameter int unsigned COUNT_W        = DEFAULT_COUNT_W,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  period_counter_if.slave  bus
);

  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  period_state_t      r_state;
  period_state_t      w_state_nxt;
  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] w_cnt_nxt;
  logic [COUNT_W-1:0] r_period;
  logic [COUNT_W-1:0] w_period_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;
  logic               r_done;
  logic               r_ready;
  logic               w_tick;

  edge_detector u_edge (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .signal_i    (bus.signal_i),
    .edge_tick_o (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_timeout <= w_timeout_nxt;
      r_done    <= (w_state_nxt == ST_DONE);
      r_ready   <= (w_state_nxt == ST_IDLE);
    end
  end

  // An edge in the same cycle as the timeout takes priority.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_cnt_nxt     = '0;
          w_period_nxt  = '0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = ST_WAIT_EDGE;
        end
      end
      ST_WAIT_EDGE: begin
        w_cnt_nxt = r_cnt + COUNT_W'(1);
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_COUNT;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_COUNT: begin
        w_cnt_nxt = r_cnt + COUNT_W'(1);
        if (w_tick) begin
          w_period_nxt = r_cnt + COUNT_W'(1);
          w_state_nxt  = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_period_nxt  = '0;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ready_o   = r_ready;
  assign bus.done_o    = r_done;
  assign bus.timeout_o = r_timeout;
  assign bus.period_o  = r_period;

endmodule

// File: tb/tb_period_counter.sv
// Directed self-checking bench for period_counter with a 100-cycle timeout.
module tb_period_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_at  = 0;
  int last_period  = 0;
  int last_timeout = 0;
  int s_cyc    = 0;
  int base     = 0;

  bit wave_en = 1'b0;
  int hi = 1;
  int lo = 1;
  int ph = 0;

  period_counter_if #(.COUNT_W(32)) bus ();

  period_counter #(.COUNT_W(32), .TIMEOUT_CYCLES(100)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive the next wave value.
  task automatic cycle();
    @(negedge clk);
    if (bus.done_o === 1'b1) begin
      done_cnt++;
      done_at      = cyc;
      last_period  = int'(bus.period_o);
      last_timeout = int'(bus.timeout_o);
    end
    if (wave_en) begin
      bus.signal_i = (ph < hi);
      ph = (ph + 1) % (hi + lo);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int b;
    int n;
    b = done_cnt;
    n = 0;
    while (done_cnt == b && n < budget) begin
      cycle();
      n++;
    end
    check(tag, done_cnt, b + 1);
  endtask

  task automatic flush();
    wave_en      = 1'b0;
    bus.signal_i = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic start_wave(input int h, input int l);
    hi = h;
    lo = l;
    ph = 0;
    wave_en = 1'b1;
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.signal_i = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_ready", bus.ready_o, 1);
    check("rst_done", bus.done_o, 0);
    check("rst_timeout", bus.timeout_o, 0);
    check("rst_period", bus.period_o, 0);
    rst = 1'b0;
    repeat (2) cycle();
    check("idle_ready", bus.ready_o, 1);
    check("idle_done", bus.done_o, 0);

    // 10 high / 10 low
    flush();
    do_start();
    check("busy_ready", bus.ready_o, 0);
    start_wave(10, 10);
    wait_done("p20_done", 200);
    check("p20_period", last_period, 20);
    check("p20_timeout", last_timeout, 0);
    check("p20_ready_in_done", bus.ready_o, 0);
    cycle();
    check("p20_ready_after", bus.ready_o, 1);
    check("p20_done_single", bus.done_o, 0);

    // Minimum period
    flush();
    do_start();
    start_wave(1, 1);
    wait_done("p2_done", 100);
    check("p2_period", last_period, 2);
    check("p2_timeout", last_timeout, 0);

    // Asymmetric 3 high / 34 low
    flush();
    do_start();
    start_wave(3, 34);
    wait_done("p37_done", 200);
    check("p37_period", last_period, 37);
    check("p37_timeout", last_timeout, 0);

    // No edge at all: timeout in WAIT_EDGE
    flush();
    do_start();
    wait_done("wto_done", 200);
    check("wto_latency", done_at - s_cyc, 100);
    check("wto_timeout", last_timeout, 1);
    check("wto_period", last_period, 0);

    // One edge only: timeout in COUNT
    flush();
    do_start();
    bus.signal_i = 1'b1;
    wait_done("cto_done", 300);
    check("cto_timeout", last_timeout, 1);
    check("cto_period", last_period, 0);

    // Edge coincides with cnt==99: edge wins
    flush();
    do_start();
    start_wave(50, 50);
    wait_done("p100_done", 300);
    check("p100_period", last_period, 100);
    check("p100_timeout", last_timeout, 0);

    // Reset during COUNT around cnt=10
    flush();
    do_start();
    bus.signal_i = 1'b1;
    repeat (14) cycle();
    base = done_cnt;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mrst_ready", bus.ready_o, 1);
    check("mrst_period", bus.period_o, 0);
    check("mrst_timeout", bus.timeout_o, 0);
    check("mrst_done", bus.done_o, 0);
    repeat (150) cycle();
    check("mrst_no_done", done_cnt, base);

    // Start pulsed during COUNT is ignored
    flush();
    do_start();
    start_wave(10, 10);
    repeat (15) cycle();
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
    wait_done("ign_done", 200);
    check("ign_period", last_period, 20);
    check("ign_timeout", last_timeout, 0);
    base = done_cnt;
    repeat (60) cycle();
    check("ign_no_extra", done_cnt, base);
    check("ign_ready", bus.ready_o, 1);
    check("ign_hold", bus.period_o, 20);

    // Back-to-back with start held high
    flush();
    bus.start_i = 1'b1;
    cycle();
    start_wave(10, 10);
    wait_done("b2b1_done", 200);
    check("b2b1_period", last_period, 20);
    wave_en = 1'b0;
    bus.signal_i = 1'b0;
    cycle();
    check("b2b_hold_period", bus.period_o, 20);
    check("b2b_idle_ready", bus.ready_o, 1);
    cycle();
    check("b2b_restart_period", bus.period_o, 0);
    check("b2b_restart_ready", bus.ready_o, 0);
    bus.start_i = 1'b0;
    start_wave(15, 15);
    wait_done("b2b2_done", 200);
    check("b2b2_period", last_period, 30);
    check("b2b2_timeout", last_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
